// File: rtl/arb_requester_pkg.sv
// Shared types and helpers for the arb_requester front end.
// Contents:
//   N_CHAN        number of requester channels
//   chan_state_t  per-channel state encoding
//   arb_lat()     grant latency seen by the requester for a given arbiter depth
package arb_pkg;

  localparam int N_CHAN = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } chan_state_t;

  function automatic int arb_lat(input int delay);
    return delay + 1;
  endfunction

endpackage

// File: rtl/arb_requester_chan.sv
// arb_req_chan: one requester channel. Queues jobs, requests the arbiter,
// counts granted beats, reports completion/preemption and filters grant
// echoes that are still in flight after the request is released.
// Optional starvation timer is built only when ARB_REQ_STARVE_EN is defined.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   job        one-cycle pulse enqueueing one job
//   gnt        this channel's grant bit from the arbiter
//   req        registered request to the arbiter
//   done       pulse, job finished all beats
//   preempt    pulse, grant lost mid-transfer (job stays queued)
//   starve     level, request waiting at least TIMEOUT cycles
//   ovf        sticky, a job pulse was dropped at a full counter
//
// state | meaning
// IDLE  | no pending job, req low
// REQ   | req high, waiting for the first grant
// XFER  | owning the arbiter, counting beats
// DRAIN | req low, ignoring grant echoes for LAT cycles
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int DELAY    = 2,
  parameter int XFER_LEN = 4,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic job,
  input  logic gnt,
  output logic req,
  output logic done,
  output logic preempt,
  output logic starve,
  output logic ovf
);

  localparam int LAT    = arb_lat(DELAY);
  localparam int BEAT_W = $clog2(XFER_LEN + 1);
  localparam int DRN_W  = $clog2(LAT + 1);
  localparam bit ONE_BEAT = (XFER_LEN == 1);
  localparam logic [CNT_W-1:0]  PEND_MAX   = '1;
  localparam logic [BEAT_W-1:0] BEAT_LOAD  = BEAT_W'(XFER_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(1);
  localparam logic [DRN_W-1:0]  DRN_LOAD   = DRN_W'(LAT - 1);

  if (XFER_LEN < 1) begin : g_bad_xfer_len
    $error("arb_req_chan: XFER_LEN must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("arb_req_chan: TIMEOUT must be at least 1");
  end

  chan_state_t r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_pend;
  logic [BEAT_W-1:0] r_beat_left;   // beats still owed after the current one
  logic [DRN_W-1:0]  r_drn_left;
  logic r_req, r_done, r_preempt, r_ovf;
  logic w_complete, w_abort, w_job_take, w_job_drop, w_pend_nz;

  always_comb begin
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_state_nxt = r_state;
    // A completing job frees a slot this same edge, so a job arriving at a
    // full counter is only dropped when nothing completes alongside it.
    w_job_drop  = 1'b0;
    w_job_take  = 1'b0;
    w_pend_nz   = (r_pend != '0) || job;

    case (r_state)
      REQ:  w_complete = gnt && ONE_BEAT;
      XFER: begin
        w_complete = gnt && (r_beat_left == BEAT_LAST);
        w_abort    = !gnt;
      end
      default: ;
    endcase

    w_job_drop = job && (r_pend == PEND_MAX) && !w_complete;
    w_job_take = job && !w_job_drop;

    case (r_state)
      IDLE:  if (w_pend_nz) w_state_nxt = REQ;
      REQ:   if (gnt) w_state_nxt = ONE_BEAT ? DRAIN : XFER;
      XFER:  if (w_complete || w_abort) w_state_nxt = DRAIN;
      DRAIN: if (r_drn_left == '0) w_state_nxt = w_pend_nz ? REQ : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_beat_left <= '0;
      r_drn_left  <= '0;
      r_req       <= 1'b0;
      r_done      <= 1'b0;
      r_preempt   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= (w_state_nxt == REQ) || (w_state_nxt == XFER);
      r_done    <= w_complete;
      r_preempt <= w_abort;
      if (w_job_drop) r_ovf <= 1'b1;

      case ({w_job_take, w_complete})
        2'b10:   r_pend <= r_pend + 1'b1;
        2'b01:   r_pend <= r_pend - 1'b1;
        default: ;
      endcase

      // The grant that moves REQ->XFER is beat 1.
      if (r_state == REQ)
        r_beat_left <= BEAT_LOAD;
      else if ((r_state == XFER) && gnt)
        r_beat_left <= r_beat_left - 1'b1;

      if (r_state != DRAIN)
        r_drn_left <= DRN_LOAD;
      else if (r_drn_left != '0)
        r_drn_left <= r_drn_left - 1'b1;
    end
  end

`ifdef ARB_REQ_STARVE_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);

  logic [WAIT_W-1:0] r_wait_left;
  logic              r_starve;

  // Only a REQ->REQ edge counts as waiting; any other edge reloads the timer.
  // The only way out of REQ is a grant, which is where starve must clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_left <= WAIT_LOAD;
      r_starve    <= 1'b0;
    end else if ((r_state == REQ) && (w_state_nxt == REQ)) begin
      if (r_wait_left != '0) r_wait_left <= r_wait_left - 1'b1;
      if (r_wait_left == WAIT_LAST) r_starve <= 1'b1;
    end else begin
      r_wait_left <= WAIT_LOAD;
      r_starve    <= 1'b0;
    end
  end

  assign starve = r_starve;
`else
  assign starve = 1'b0;
`endif

  assign req     = r_req;
  assign done    = r_done;
  assign preempt = r_preempt;
  assign ovf     = r_ovf;

endmodule

// File: rtl/arb_requester.sv
// arb_requester: three-channel requester front end for the fixed-priority
// pri_arbiter. Each bit of every port belongs to one independent channel
// (arb_req_chan); this level only fans the bits in and out.
// Build option: define ARB_REQ_STARVE_EN to build the starvation timers,
// otherwise starve is tied low.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   job       per-channel job enqueue pulses
//   gnt       arbiter grant, one-hot or zero
//   req       registered requests to the arbiter
//   done      per-channel job-complete pulses
//   preempt   per-channel grant-lost pulses
//   starve    per-channel starvation level
//   ovf       per-channel sticky job-drop flag
module arb_requester
  import arb_pkg::*;
#(
  parameter int DELAY    = 2,
  parameter int XFER_LEN = 4,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CHAN-1:0] job,
  input  logic [N_CHAN-1:0] gnt,
  output logic [N_CHAN-1:0] req,
  output logic [N_CHAN-1:0] done,
  output logic [N_CHAN-1:0] preempt,
  output logic [N_CHAN-1:0] starve,
  output logic [N_CHAN-1:0] ovf
);

  for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
    arb_req_chan #(
      .DELAY    (DELAY),
      .XFER_LEN (XFER_LEN),
      .CNT_W    (CNT_W),
      .TIMEOUT  (TIMEOUT)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .job     (job[gi]),
      .gnt     (gnt[gi]),
      .req     (req[gi]),
      .done    (done[gi]),
      .preempt (preempt[gi]),
      .starve  (starve[gi]),
      .ovf     (ovf[gi])
    );
  end

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;
  import arb_pkg::*;

  localparam int DELAY    = 2;
  localparam int XFER_LEN = 4;
  localparam int CNT_W    = 4;
  localparam int TIMEOUT  = 32;
  localparam int LAT      = DELAY + 1;
  localparam int PMAX     = (1 << CNT_W) - 1;
`ifdef ARB_REQ_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] job = '0;
  logic [2:0] gnt = '0;
  logic [2:0] req, done, preempt, starve, ovf;

  always #5 clk = ~clk;

  arb_requester #(.DELAY(DELAY), .XFER_LEN(XFER_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .job(job), .gnt(gnt),
    .req(req), .done(done), .preempt(preempt), .starve(starve), .ovf(ovf)
  );

  int vectors = 0, miscompares = 0, n_checks = 0, cyc = 0;

  // Behavioural model: per channel a job queue depth, whether it is asking,
  // how many beats it holds, how long it must still cool down, and how long
  // it has been asking without any beat.
  int m_pend[N_CHAN], m_beats[N_CHAN], m_cool[N_CHAN], m_waited[N_CHAN];
  bit m_want[N_CHAN], m_ovf[N_CHAN];
  logic [2:0] e_req = '0, e_done = '0, e_pre = '0, e_starve = '0, e_ovf = '0;

  // Arbiter stand-in: reqq[0] is the request vector DELAY cycles ago.
  logic [2:0] reqq[$];
  bit         force_en = 1'b0;
  logic [2:0] force_gnt = '0;
  int         noise_pct = 0;

  int  n_done[N_CHAN], n_pre[N_CHAN], stale1;
  bit  seen_starve[N_CHAN];
  int  rises0[$], falls0[$], dones0[$];
  logic prev_req0 = 1'b0;

  function automatic logic [2:0] pick(input logic [2:0] r);
    if (r[0]) return 3'b001;
    if (r[1]) return 3'b010;
    if (r[2]) return 3'b100;
    return 3'b000;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  task automatic check3(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic [2:0] j, input logic [2:0] g, input logic r);
    for (int c = 0; c < N_CHAN; c++) begin
      bit fin, cut;
      fin = 1'b0;
      cut = 1'b0;
      if (r) begin
        m_pend[c] = 0; m_beats[c] = 0; m_cool[c] = 0; m_waited[c] = 0;
        m_want[c] = 1'b0; m_ovf[c] = 1'b0;
      end else begin
        if (m_want[c]) begin
          if (g[c]) begin
            m_beats[c]++;
            if (m_beats[c] == XFER_LEN) fin = 1'b1;
          end else if (m_beats[c] > 0) begin
            cut = 1'b1;
          end
          if (fin || cut) begin
            m_want[c]  = 1'b0;
            m_beats[c] = 0;
            m_cool[c]  = LAT;
          end
        end else if (m_cool[c] > 0) begin
          m_cool[c]--;
        end
        if (j[c]) begin
          if (m_pend[c] < PMAX || fin) m_pend[c]++;
          else m_ovf[c] = 1'b1;
        end
        if (fin) m_pend[c]--;
        if (!m_want[c] && m_cool[c] == 0 && m_pend[c] > 0) begin
          m_want[c]   = 1'b1;
          m_waited[c] = 0;
        end
        if (m_want[c] && m_beats[c] == 0) m_waited[c]++;
        else m_waited[c] = 0;
      end
      e_req[c]    = m_want[c];
      e_done[c]   = fin;
      e_pre[c]    = cut;
      e_ovf[c]    = m_ovf[c];
      e_starve[c] = STARVE_ON && m_want[c] && (m_beats[c] == 0) && (m_waited[c] > TIMEOUT);
    end
  endtask

  task automatic clear_log();
    for (int c = 0; c < N_CHAN; c++) begin
      n_done[c] = 0; n_pre[c] = 0; seen_starve[c] = 1'b0;
    end
    stale1 = 0;
    rises0.delete(); falls0.delete(); dones0.delete();
  endtask

  task automatic tick(input logic [2:0] j, input logic r);
    logic [2:0] g;
    g = force_en ? force_gnt : pick(reqq[0]);
    if (noise_pct > 0 && int'($urandom_range(99)) < noise_pct)
      g = pick(3'($urandom_range(7)));
    if (g[1] && !req[1]) stale1++;
    job = j;
    gnt = g;
    rst = r;
    @(posedge clk);
    #1;
    cyc++;
    vectors++;
    model_step(j, g, r);
    check3("req", req, e_req);
    check3("done", done, e_done);
    check3("preempt", preempt, e_pre);
    check3("starve", starve, e_starve);
    check3("ovf", ovf, e_ovf);
    for (int c = 0; c < N_CHAN; c++) begin
      if (done[c]) n_done[c]++;
      if (preempt[c]) n_pre[c]++;
      if (starve[c]) seen_starve[c] = 1'b1;
    end
    if (req[0] && !prev_req0) rises0.push_back(cyc);
    if (!req[0] && prev_req0) falls0.push_back(cyc);
    if (done[0]) dones0.push_back(cyc);
    prev_req0 = req[0];
    reqq.push_back(req);
    void'(reqq.pop_front());
  endtask

  initial begin
    int jc;
    logic [2:0] rj;
    for (int i = 0; i <= DELAY; i++) reqq.push_back(3'b000);
    clear_log();

    // Reset state
    repeat (3) tick(3'b000, 1'b1);
    check3("rst_req", req, 3'b000);
    check3("rst_ovf", ovf, 3'b000);

    // Single job then a second queued job on channel 0
    tick(3'b000, 1'b0);
    clear_log();
    tick(3'b001, 1'b0);
    jc = cyc;
    tick(3'b001, 1'b0);
    repeat (30) tick(3'b000, 1'b0);
    check_int("single_req_rise", qget(rises0, 0), jc);
    check_int("single_done_lat", qget(dones0, 0) - qget(rises0, 0), LAT + XFER_LEN - 1);
    check_int("single_req_fall", qget(falls0, 0), qget(dones0, 0));
    check_int("b2b_req_gap", qget(rises0, 1) - qget(falls0, 0), LAT);
    check_int("b2b_done_count", dones0.size(), 2);

    // Preemption of channel 2 by channel 0
    clear_log();
    tick(3'b100, 1'b0);
    repeat (2) tick(3'b000, 1'b0);
    tick(3'b001, 1'b0);
    repeat (40) tick(3'b000, 1'b0);
    check_int("pre_ch2_preempt", n_pre[2], 1);
    check_int("pre_ch0_done", n_done[0], 1);
    check_int("pre_ch2_done", n_done[2], 1);
    check_int("pre_ch0_preempt", n_pre[0], 0);

    // Stale grant echo after channel 1 releases
    clear_log();
    tick(3'b010, 1'b0);
    repeat (25) tick(3'b000, 1'b0);
    check_int("stale_done_count", n_done[1], 1);
    check_int("stale_echo_cycles", stale1, DELAY);

    // Saturation of channel 1 while channel 0 keeps it blocked
    tick(3'b000, 1'b1);
    clear_log();
    repeat (8) tick(3'b001, 1'b0);
    repeat (17) tick(3'b010, 1'b0);
    check3("sat_ovf_set", ovf, 3'b010);
    repeat (300) tick(3'b000, 1'b0);
    check_int("sat_ch1_done", n_done[1], PMAX);
    check_int("sat_ch0_done", n_done[0], 8);
    check3("sat_ovf_sticky", ovf, 3'b010);

    // Starvation: grant pinned to channel 0, channel 2 waits
    tick(3'b000, 1'b1);
    clear_log();
    force_en  = 1'b1;
    force_gnt = 3'b001;
    repeat (6) tick(3'b001, 1'b0);
    tick(3'b100, 1'b0);
    repeat (45) tick(3'b000, 1'b0);
    check_int("starve_seen", int'(seen_starve[2]), int'(STARVE_ON));
    force_en = 1'b0;
    repeat (150) tick(3'b000, 1'b0);
    check3("starve_cleared", starve, 3'b000);
    check_int("starve_ch2_done", n_done[2], 1);

    // Reset in the middle of a transfer
    tick(3'b000, 1'b1);
    clear_log();
    tick(3'b001, 1'b0);
    repeat (4) tick(3'b000, 1'b0);
    tick(3'b000, 1'b1);
    check3("midrst_req", req, 3'b000);
    check3("midrst_done", done, 3'b000);
    repeat (20) tick(3'b000, 1'b0);
    check_int("midrst_no_done", n_done[0], 0);
    check_int("midrst_no_rerequest", rises0.size(), 1);

    // Random traffic with grant noise and occasional reset
    tick(3'b000, 1'b1);
    noise_pct = 10;
    repeat (3000) begin
      rj[0] = ($urandom_range(99) < 12);
      rj[1] = ($urandom_range(99) < 12);
      rj[2] = ($urandom_range(99) < 12);
      tick(rj, ($urandom_range(499) == 0));
    end
    noise_pct = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
